// File: rtl/timer_round.sv
// rtl/timer_round.sv - prescaled up-counter with one-shot / auto-wrap terminal handling
// Three-state IDLE/RUN/DONE controller; all outputs come straight from registers.
module timer_round #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk_i,
    input  logic         r_i,
    input  logic         e_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         mode_i,
    input  logic [N-1:0] limit_i,
    output logic [N-1:0] tempo_o,
    output logic         end_time,
    output logic         expired_o,
    output logic         run_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    tempo_q;
    logic [PW-1:0]   pre_q;
    logic            end_q;
    logic            expired_q;
    logic            run_q;
    logic            tempo_tick;

    // With DIV=1 pre_q stays 0 and PRE_LAST is 0, so every accepted e_i is a tick.
    assign tempo_tick = e_i && (pre_q == PRE_LAST);

    always_ff @(posedge clk_i) begin
        if (r_i) begin
            state_q   <= IDLE;
            tempo_q   <= '0;
            pre_q     <= '0;
            end_q     <= 1'b0;
            expired_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!stop_i && start_i) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                        tempo_q <= '0;
                        pre_q   <= '0;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_q   <= IDLE;
                        run_q     <= 1'b0;
                        tempo_q   <= '0;
                        pre_q     <= '0;
                        expired_q <= 1'b0;
                    end else if (start_i) begin
                        tempo_q <= '0;
                        pre_q   <= '0;
                    end else if (e_i) begin
                        if (tempo_tick) begin
                            pre_q <= '0;
                            // >= so a limit lowered below the count still terminates
                            if (tempo_q >= limit_i) begin
                                end_q <= 1'b1;
                                if (mode_i) begin
                                    tempo_q <= '0;
                                end else begin
                                    state_q   <= DONE;
                                    run_q     <= 1'b0;
                                    expired_q <= 1'b1;
                                end
                            end else begin
                                tempo_q <= tempo_q + N'(1);
                            end
                        end else begin
                            pre_q <= pre_q + PW'(1);
                        end
                    end
                end
                DONE: begin
                    if (stop_i) begin
                        state_q   <= IDLE;
                        tempo_q   <= '0;
                        pre_q     <= '0;
                        expired_q <= 1'b0;
                    end else if (start_i) begin
                        state_q   <= RUN;
                        run_q     <= 1'b1;
                        tempo_q   <= '0;
                        pre_q     <= '0;
                        expired_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tempo_o   = tempo_q;
    assign end_time  = end_q;
    assign expired_o = expired_q;
    assign run_o     = run_q;

endmodule

// File: tb/tb_timer_round.sv
// tb/tb_timer_round.sv - checks timer_round (DIV=1 and DIV=3) against a behavioural model
module tb_timer_round;

    logic       clk = 1'b0;
    logic       r = 1'b0, e = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [3:0] limit = 4'd0;

    logic [3:0] t1, t3;
    logic       end1, end3, exp1, exp3, run1, run3;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    timer_round #(.N(4), .DIV(1)) u_d1 (
        .clk_i(clk), .r_i(r), .e_i(e), .start_i(start), .stop_i(stop), .mode_i(mode),
        .limit_i(limit), .tempo_o(t1), .end_time(end1), .expired_o(exp1), .run_o(run1)
    );

    timer_round #(.N(4), .DIV(3)) u_d3 (
        .clk_i(clk), .r_i(r), .e_i(e), .start_i(start), .stop_i(stop), .mode_i(mode),
        .limit_i(limit), .tempo_o(t3), .end_time(end3), .expired_o(exp3), .run_o(run3)
    );

    // Model: phase 0=idle 1=running 2=done; acc counts accepted e_i since the last tempo tick.
    int m_ph[2], m_t[2], m_acc[2];
    bit m_end[2], m_exp[2];
    int divs[2] = '{1, 3};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_end[k] = 1'b0;
            if (r) begin
                m_ph[k] = 0; m_t[k] = 0; m_acc[k] = 0; m_exp[k] = 1'b0;
            end else if (stop) begin
                if (m_ph[k] != 0) begin
                    m_ph[k] = 0; m_t[k] = 0; m_acc[k] = 0; m_exp[k] = 1'b0;
                end
            end else if (start) begin
                m_ph[k] = 1; m_t[k] = 0; m_acc[k] = 0; m_exp[k] = 1'b0;
            end else if (m_ph[k] == 1 && e) begin
                m_acc[k]++;
                if (m_acc[k] == divs[k]) begin
                    m_acc[k] = 0;
                    if (m_t[k] >= int'(limit)) begin
                        m_end[k] = 1'b1;
                        if (mode) m_t[k] = 0;
                        else begin m_ph[k] = 2; m_exp[k] = 1'b1; end
                    end else begin
                        m_t[k]++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("d1.tempo", int'(t1), m_t[0]);
            check("d1.end", int'(end1), int'(m_end[0]));
            check("d1.expired", int'(exp1), int'(m_exp[0]));
            check("d1.run", int'(run1), int'(m_ph[0] == 1));
            check("d3.tempo", int'(t3), m_t[1]);
            check("d3.end", int'(end3), int'(m_end[1]));
            check("d3.expired", int'(exp3), int'(m_exp[1]));
            check("d3.run", int'(run3), int'(m_ph[1] == 1));
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit rr, input bit ss, input bit sp, input bit ee);
        r = rr; start = ss; stop = sp; e = ee;
    endtask

    task automatic reset_start(input int lim, input bit md);
        limit = 4'(lim); mode = md;
        set_in(1, 0, 0, 0); edge1();
        set_in(0, 1, 0, 0); edge1();
        set_in(0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        set_in(1, 1, 1, 1); edge1();
        chk_en = 1'b1;
        check("rst.tempo", int'(t1), 0);
        check("rst.end", int'(end1), 0);
        check("rst.expired", int'(exp3), 0);
        check("rst.run", int'(run3), 0);

        // Auto-wrap at limit 9, DIV=1: period of 10 ticks
        reset_start(9, 1);
        e = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            edge1();
            check("wrap.tempo", int'(t1), i % 10);
            check("wrap.end", int'(end1), int'(i % 10 == 0));
        end

        // One-shot, DIV=3, limit 2: terminal on the 9th e_i, then held in DONE
        reset_start(2, 0);
        e = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            edge1();
            check("oneshot.tempo", int'(t3), (i < 3) ? 0 : (i < 6) ? 1 : 2);
            check("oneshot.end", int'(end3), int'(i == 9));
            check("oneshot.expired", int'(exp3), int'(i >= 9));
        end
        check("oneshot.run", int'(run3), 0);

        // Limit lowered below the count, both modes
        for (int md = 1; md >= 0; md--) begin
            reset_start(9, 1'(md));
            e = 1'b1;
            repeat (5) edge1();
            check("lower.pre", int'(t1), 5);
            limit = 4'd3;
            edge1();
            check("lower.end", int'(end1), 1);
            check("lower.tempo", int'(t1), md ? 0 : 5);
            check("lower.run", int'(run1), md);
            e = 1'b0;
            edge1();
            check("lower.end_once", int'(end1), 0);
        end

        // Limit 0 with auto-wrap: pulse every tick, count stays 0
        reset_start(0, 1);
        e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge1();
            check("lim0.end", int'(end1), 1);
            check("lim0.tempo", int'(t1), 0);
        end

        // stop beats start beats terminal tick
        set_in(0, 1, 1, 1); edge1();
        check("prio.run", int'(run1), 0);
        check("prio.end", int'(end1), 0);
        set_in(0, 1, 0, 1); edge1();
        check("prio.run2", int'(run1), 1);
        check("prio.end2", int'(end1), 0);
        edge1();
        check("prio.restart_end", int'(end1), 0);
        check("prio.restart_tempo", int'(t1), 0);

        // Reset mid-count discards the count; e_i alone does not restart
        reset_start(15, 1);
        e = 1'b1;
        repeat (7) edge1();
        check("rmid.pre", int'(t1), 7);
        set_in(1, 0, 0, 1); edge1();
        check("rmid.tempo", int'(t1), 0);
        check("rmid.run", int'(run1), 0);
        set_in(0, 0, 0, 1);
        repeat (3) edge1();
        check("rmid.idle_e", int'(t1), 0);
        set_in(0, 1, 0, 1); edge1();
        set_in(0, 0, 0, 1); edge1();
        check("rmid.first", int'(t1), 1);

        // Limit 15 reaches 15 and terminates without overflow
        reset_start(15, 0);
        e = 1'b1;
        repeat (15) edge1();
        check("max.tempo", int'(t1), 15);
        edge1();
        check("max.end", int'(end1), 1);
        check("max.hold", int'(t1), 15);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            r     = ($urandom_range(0, 99) < 2);
            stop  = ($urandom_range(0, 99) < 3);
            start = ($urandom_range(0, 99) < 5);
            e     = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 49) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 15) == 0) limit = 4'($urandom);
            edge1();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
